// File: rtl/mad_mem_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals around mad_mem_arbiter.
// slave is the arbiter's view; master is the pipeline/memory side.
interface mad_mem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_valid;
  logic                  if_stall;

  logic                  dm_req;
  logic                  dm_we;
  logic                  dm_wide;
  logic [ADDR_W-1:0]     dm_addr;
  logic [2*DATA_W-1:0]   dm_wdata;
  logic [2*DATA_W-1:0]   dm_rdata;
  logic                  dm_done;
  logic                  dm_stall;

  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_valid, if_stall,
    input  dm_req, dm_we, dm_wide, dm_addr, dm_wdata,
    output dm_rdata, dm_done, dm_stall,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_valid, if_stall,
    output dm_req, dm_we, dm_wide, dm_addr, dm_wdata,
    input  dm_rdata, dm_done, dm_stall,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mad_mem_arbiter.sv
// Single-port memory arbiter for the MAD unified memory: data accesses win over
// fetch, 32-bit accesses are split into two word cycles (high word first).
module mad_mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  mad_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, D_WORD2, D_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic                wide_q;
  logic [DATA_W-1:0]   wlo_q;
  logic [DATA_W-1:0]   hi_q;
  logic                if_valid_q;

  logic                accept;
  logic                fetch;
  logic                done;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [2*DATA_W-1:0] dm_rdata;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      if_valid_q <= 1'b0;
      hi_q       <= '0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= fetch;
      if (state_q == D_WORD2) hi_q <= bus.mem_rdata;
    end
  end

  // Access context is only consumed after an accept, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= bus.dm_addr;
      we_q   <= bus.dm_we;
      wide_q <= bus.dm_wide;
      wlo_q  <= bus.dm_wdata[DATA_W-1:0];
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    fetch     = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    dm_rdata  = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (bus.dm_req) begin
            accept    = 1'b1;
            mem_addr  = bus.dm_addr;
            mem_we    = bus.dm_we;
            mem_wdata = bus.dm_wide ? bus.dm_wdata[2*DATA_W-1:DATA_W]
                                    : bus.dm_wdata[DATA_W-1:0];
            state_d   = bus.dm_wide ? D_WORD2 : D_DONE;
          end else if (bus.if_req) begin
            fetch    = 1'b1;
            mem_addr = bus.if_addr;
          end
        end
        D_WORD2: begin
          mem_addr  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          mem_we    = we_q;
          mem_wdata = wlo_q;
          state_d   = D_DONE;
        end
        D_DONE: begin
          done = 1'b1;
          if (!we_q)
            dm_rdata = wide_q ? {hi_q, bus.mem_rdata} : {{DATA_W{1'b0}}, bus.mem_rdata};
          // The port is free again for the word-return cycle of the data access.
          if (bus.if_req) begin
            fetch    = 1'b1;
            mem_addr = bus.if_addr;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = mem_wdata;
  assign bus.dm_rdata  = dm_rdata;
  assign bus.dm_done   = done;
  assign bus.dm_stall  = bus.dm_req && !done;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_stall  = bus.if_req && !fetch;

endmodule

// File: doc/mad_mem_arbiter.md
# mad_mem_arbiter

Single-port memory arbiter and access sequencer for the MAD RISC processor's unified 2048×16 instruction/data memory. It shares the one memory port between two requesters: the fetch stage (16-bit instruction reads) and the memory stage (16-bit or 32-bit loads and stores, e.g. PC/flag push-pop on CALL/RET/INT). 32-bit accesses are sequenced as two word cycles. The block also generates stall signals so the pipeline freezes while it waits for the port.

## Interface
- ADDR_W, 11, memory word-address width (address arithmetic wraps mod 2^ADDR_W)
- DATA_W, 16, memory word width; wide accesses are 2×DATA_W

- Clk  in  1  system clock; all state changes on rising edge
- Rst  in  1  reset, synchronous and active-high
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch word address
- if_rdata  out  DATA_W  fetched word (combinational from mem_rdata), meaningful only while if_valid=1
- if_valid  out  1  fetch data valid (registered)
- if_stall  out  1  fetch request not issued this cycle
- dm_req  in  1  data request
- dm_we  in  1  1 = store, 0 = load
- dm_wide  in  1  1 = 32-bit access (two words), 0 = 16-bit
- dm_addr  in  ADDR_W  data word address (high word at dm_addr when wide)
- dm_wdata  in  2×DATA_W  store data; narrow store uses [15:0]
- dm_rdata  out  2×DATA_W  load data, valid only while dm_done=1
- dm_done  out  1  one-cycle completion pulse
- dm_stall  out  1  dm_req && !dm_done
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; synchronous read, valid the cycle after the address is presented

## Operation
- Data has priority over fetch; only one memory access can be issued per cycle.
- **FSM states:** IDLE, D_WORD2, D_DONE.
- **IDLE, dm_req=1 (accept):**
  - Issue the data access: mem_addr=dm_addr, mem_we=dm_we.
  - mem_wdata = dm_wide ? dm_wdata[31:16] : dm_wdata[15:0].
  - Latch dm_addr, dm_we, dm_wide and dm_wdata[15:0].
  - Next state: dm_wide ? D_WORD2 : D_DONE.
- **IDLE, dm_req=0, if_req=1:** issue the fetch (mem_addr=if_addr, mem_we=0); if_valid=1 next cycle.
- **IDLE, no request:** mem_addr=0, mem_we=0.
- **D_WORD2:**
  - mem_addr = latched addr+1 (wraps 2047→0), mem_we = latched we, mem_wdata = latched wdata[15:0].
  - Capture mem_rdata into hi_q (the load's high word).
  - Fetch is blocked. Next state: D_DONE.
- **D_DONE:**
  - dm_done=1.
  - dm_rdata = wide ? {hi_q, mem_rdata} : {16'h0000, mem_rdata}.
  - For a store, dm_rdata is don't-care (drive 0).
  - dm_req is ignored in this state; the next data request is accepted in the following IDLE.
  - The port is free: if if_req=1, issue the fetch. Next state: IDLE.
- **if_stall:** if_stall = if_req && (no fetch issued this cycle). This is combinational.
- **Requester rule:** the memory-stage requester holds dm_req and its signals through the accept cycle and keeps dm_req high until dm_done. Changes after acceptance are ignored.

## Timing
- **Narrow access:** accept at t, dm_done at t+1. Fetch is stalled at t if requested, and may issue at t+1.
- **Wide access:** accept at t, second word at t+1, dm_done at t+2. Fetch is stalled at t and t+1.
- **Fetch latency:** issue at t, if_valid/if_rdata at t+1. Back-to-back fetches give one word per cycle.
- **Overlap:** if_valid and dm_done may never be asserted in the same cycle. A fetch issued at t returns at t+1. A data access accepted at t+1 finishes at t+2 or later, so the pipelined reads never collide.
- **Back-to-back data requests:** at most one data accept every 2 cycles for narrow accesses and every 3 for wide.
- **Reset (Rst=1 at an edge):**
  - state←IDLE, if_valid←0, hi_q←0.
  - While Rst=1: mem_we=0, mem_addr=0, dm_done=0, if_stall=if_req, dm_stall=dm_req.
- **Reset mid-wide-store:** if reset is taken during D_WORD2, the first word stays written and the second word is not written. The store is never resumed.
- **Reset mid-access:** a pending dm_done or if_valid is dropped.

## Test plan
- **Reset:** Rst=1 for 2 cycles with if_req=1 and dm_req=1 -> mem_we=0, dm_done=0, if_valid=0, state IDLE; the first access issues in the cycle after Rst falls.
- **Fetch stream:** if_req held, if_addr 0,1,2,3 on consecutive cycles, memory preloaded 0x0019,0xFFFF,0xF320,0xAABD -> if_valid high from the second cycle; if_rdata returns those values in order with no stall.
- **Narrow load vs fetch:** dm_req load at 0x100 (mem=0x1234) together with if_req -> fetch stalled 1 cycle; dm_done next cycle with dm_rdata=0x00001234; the fetch issues in the D_DONE cycle; if_valid follows one cycle later.
- **Wide store then load at 0x7FF:** store 0xDEADBEEF -> mem[0x7FF]=0xDEAD, mem[0x000]=0xBEEF (address wraps); dm_done after 2 cycles. A wide load of 0x7FF then returns 0xDEADBEEF.
- **Reset during D_WORD2 of a wide store:** store 0xCAFEF00D to 0x200, Rst asserted in the D_WORD2 cycle -> mem[0x200]=0xCAFE, mem[0x201] unchanged, no dm_done.
- **Back-to-back data:** two narrow loads with dm_req held -> second accepted 2 cycles after the first; dm_stall=1 except in the dm_done cycles.
